// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_PARITY = 3'd3,
    R_STOP   = 3'd4,
    R_BREAK  = 3'd5
  } rx_state_t;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int CELL_CLKS_DEF = 16;
  localparam int WORD_LEN_DEF  = 8;

  // Even-parity bit of a zero-extended data word.
  function automatic logic xor_reduce(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_deser_rx_line_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module rx_line_sync
  import uart_rx_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic rxs
);

  logic meta_r;

  // Two-stage capture of the pad input into the sys_clk domain.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_r <= HI;
      rxs    <= HI;
    end else begin
      meta_r <= din;
      rxs    <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: start validation, mid-cell sampling, framing check.
// Optional parity bit handling is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int CELL_CLKS  = CELL_CLKS_DEF,
  parameter int WORD_LEN   = WORD_LEN_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                uart_recH,
  output logic [WORD_LEN-1:0] rec_dataH,
  output logic                rec_readyH,
  output logic                frame_errH,
  output logic                par_errH,
  output logic                rec_busyH
);

  localparam int CW = $clog2(CELL_CLKS);
  localparam int BW = $clog2(WORD_LEN + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CELL_CLKS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CELL_CLKS - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LEN - 1);

  rx_state_t     state_r;
  logic [CW-1:0] cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic [WORD_LEN-1:0] shift_r;
  logic          rxs_s;

  rx_line_sync u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (uart_recH),
    .rxs     (rxs_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_fail_r;
  logic par_err_r;
  logic par_exp_s;

  assign par_exp_s = xor_reduce(32'(shift_r)) ^ PARITY_ODD;
  assign par_errH  = par_err_r;
`else
  assign par_errH = LO;
`endif

  // Receive FSM; every output is registered alongside the state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= R_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {WORD_LEN{1'b0}};
      rec_dataH  <= {WORD_LEN{1'b0}};
      rec_readyH <= LO;
      frame_errH <= LO;
      rec_busyH  <= LO;
`ifdef UART_RX_PARITY_EN
      par_fail_r <= LO;
      par_err_r  <= LO;
`endif
    end else begin
      rec_readyH <= LO;
      frame_errH <= LO;
`ifdef UART_RX_PARITY_EN
      par_err_r  <= LO;
`endif
      case (state_r)
        R_IDLE: begin
          if (rxs_s == LO) begin
            state_r   <= R_START;
            cnt_r     <= CNT_ZERO;
            rec_busyH <= HI;
          end
        end
        R_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= BIT_ZERO;
            if (rxs_s == LO) begin
              state_r <= R_DATA;
`ifdef UART_RX_PARITY_EN
              par_fail_r <= LO;
`endif
            end else begin
              state_r   <= R_IDLE;
              rec_busyH <= LO;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        R_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            shift_r   <= {rxs_s, shift_r[WORD_LEN-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_r <= R_PARITY;
`else
              state_r <= R_STOP;
`endif
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        R_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r      <= CNT_ZERO;
            par_fail_r <= (rxs_s != par_exp_s);
            state_r    <= R_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        R_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
            if (rxs_s == HI) begin
              rec_dataH  <= shift_r;
              rec_readyH <= HI;
              rec_busyH  <= LO;
              state_r    <= R_IDLE;
`ifdef UART_RX_PARITY_EN
              par_err_r  <= par_fail_r;
`endif
            end else begin
              frame_errH <= HI;
              state_r    <= R_BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        // Stay here while the line is held low so a break reports once.
        R_BREAK: begin
          if (rxs_s == HI) begin
            state_r   <= R_IDLE;
            rec_busyH <= LO;
          end
        end
        default: begin
          state_r   <= R_IDLE;
          cnt_r     <= CNT_ZERO;
          bit_cnt_r <= BIT_ZERO;
          rec_busyH <= LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed cases plus random frames,
// checked by a scoreboard against a byte-level frame model.
module tb_uart_rx_deser;

  localparam int CELL = 16;
  localparam int WL   = 8;
  localparam bit ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME = (WL + 2 + PAR_BITS) * CELL;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          uart_recH = 1'b1;
  logic [WL-1:0] rec_dataH;
  logic          rec_readyH;
  logic          frame_errH;
  logic          par_errH;
  logic          rec_busyH;

  uart_rx_deser #(.CELL_CLKS(CELL), .WORD_LEN(WL), .PARITY_ODD(ODD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_recH  (uart_recH),
    .rec_dataH  (rec_dataH),
    .rec_readyH (rec_readyH),
    .frame_errH (frame_errH),
    .par_errH   (par_errH),
    .rec_busyH  (rec_busyH)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit            is_ferr;
    logic [WL-1:0] data;
    bit            par_err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            ready_times[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [WL-1:0] last_good = '0;
  bit            prev_strobe = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected frame outcome.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (rec_readyH || frame_errH) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, rec_readyH, frame_errH}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {30'd0, rec_readyH, frame_errH}, mon_e.is_ferr ? 32'd1 : 32'd2);
          if (mon_e.is_ferr) begin
            check("data_held_on_ferr", rec_dataH, last_good);
          end else begin
            check("rx_data", rec_dataH, mon_e.data);
            check("par_err", par_errH, mon_e.par_err);
            last_good = mon_e.data;
            ready_times.push_back(cyc);
          end
        end
        if (prev_strobe) check("strobe_back_to_back", 32'd1, 32'd0);
      end
      if (par_errH && !rec_readyH) check("par_err_without_ready", 32'd0, 32'd1);
      prev_strobe = rec_readyH || frame_errH;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    uart_recH = b;
    repeat (n) @(negedge sys_clk);
  endtask

  // Model: a good stop yields the byte (parity error if sent bit disagrees with
  // the data's parity), a low stop yields one framing error.
  task automatic send_frame(input logic [WL-1:0] d, input logic stop, input logic pb,
                            input int hold_low, input int gap);
    exp_t e;
    e.is_ferr = !stop;
    e.data    = d;
    e.par_err = (PAR_BITS == 1) && (pb != ((^d) ^ ODD));
    exp_q.push_back(e);
    drive_bit(1'b0, CELL);
    for (int i = 0; i < WL; i++) drive_bit(d[i], CELL);
    if (PAR_BITS == 1) drive_bit(pb, CELL);
    drive_bit(stop, CELL);
    if (hold_low > 0) drive_bit(1'b0, hold_low);
    if (gap > 0) drive_bit(1'b1, gap);
    else uart_recH = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * FRAME) begin
      @(negedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    repeat (4) @(negedge sys_clk);
  endtask

  function automatic logic good_par(input logic [WL-1:0] d);
    return (^d) ^ ODD;
  endfunction

  initial begin
    logic [WL-1:0] d;
    logic          stop;
    logic          pb;

    repeat (3) @(negedge sys_clk);
    check("rst_data", rec_dataH, 32'd0);
    check("rst_ready", rec_readyH, 32'd0);
    check("rst_ferr", frame_errH, 32'd0);
    check("rst_perr", par_errH, 32'd0);
    check("rst_busy", rec_busyH, 32'd0);
    sys_rst = 1'b0;
    drive_bit(1'b1, 20);

    // Single frame.
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 0, 20);
    wait_drain();
    check("busy_after_a5", rec_busyH, 32'd0);

    // Back-to-back frames with no idle gap.
    ready_times.delete();
    send_frame(8'h00, 1'b1, good_par(8'h00), 0, 0);
    send_frame(8'hFF, 1'b1, good_par(8'hFF), 0, 20);
    wait_drain();
    if (ready_times.size() == 2) check("b2b_spacing", ready_times[1] - ready_times[0], FRAME);
    else check("b2b_count", ready_times.size(), 32'd2);

    // Short low glitch is a false start.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 14);
    check("false_start_busy", rec_busyH, 32'd0);
    check("false_start_data", rec_dataH, 32'hFF);

    // Framing error followed by a held-low line, then a good frame.
    send_frame(8'h3C, 1'b0, good_par(8'h3C), 40, 20);
    send_frame(8'h81, 1'b1, good_par(8'h81), 0, 20);
    wait_drain();

    // Reset in the middle of data bit 4; bits 4..7 are high so no restart.
    d = 8'hF3;
    drive_bit(1'b0, CELL);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CELL);
    drive_bit(d[4], 8);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_data", rec_dataH, 32'd0);
    check("midrst_ready", rec_readyH, 32'd0);
    check("midrst_ferr", frame_errH, 32'd0);
    check("midrst_busy", rec_busyH, 32'd0);
    sys_rst = 1'b0;
    last_good = '0;
    drive_bit(d[4], 7);
    for (int i = 5; i < WL; i++) drive_bit(d[i], CELL);
    drive_bit(1'b1, CELL + 20);
    check("midrst_no_strobe_data", rec_dataH, 32'd0);
    send_frame(8'h5A, 1'b1, good_par(8'h5A), 0, 20);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, 20);
    send_frame(8'h07, 1'b1, 1'b1, 0, 20);
    wait_drain();
`endif

    // Random frames: random data, occasional bad stop, random parity bit and gaps.
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      pb   = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      send_frame(d, stop, pb, 0, stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)));
    end
    wait_drain();
    check("final_busy", rec_busyH, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
